uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter that responds on the CPU data-memory bus (ce/we/sel/addr/data), in parallel with data_ram under an external address decode. The CPU stores bytes into an internal FIFO. A baud-rate state machine serializes them onto `tx` as 8N1 frames, LSB first. A status register lets polling software avoid overflow.

## Interface
Parameters:
- FIFO_DEPTH, 8, FIFO entries; power of two, 2..16
- DEFAULT_DIV, 16'd434, reset value of BAUDDIV (cycles per bit)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- ce  input  1  chip enable from external address decode
- we  input  1  1 = write, 0 = read
- sel  input  4  byte enables; any nonzero value qualifies a write
- addr  input  32  only addr[3:2] decoded
- data_i  input  32  write data from CPU
- data_o  output  32  read data to CPU
- tx  output  1  serial line, idles high

## Operation
- Register map, by addr[3:2]:
  - 0 TXDATA (W): push data_i[7:0]. Reads return 0.
  - 1 STATUS (R/W):
    - bit0 full, bit1 empty, bit2 busy (frame in progress), bit3 overflow (sticky), bits[7:4] FIFO count, rest 0.
    - Writing 1 to bit3 clears overflow. Other bits are read-only.
  - 2 BAUDDIV (R/W): bits[15:0] cycles per bit. Value 0 is treated as 1. Upper bits read 0.
  - 3: reads 0, writes ignored.
- Write strobe: ce & we & (sel != 0), sampled at the clk rising edge.
- Read: data_o is combinational from registers when ce & ~we; otherwise 32'h0.
- FIFO push to TXDATA when full:
  - Byte dropped, overflow set.
  - Exception: if a pop occurs in the same cycle, the push is accepted.
- State machine: IDLE, START, DATA, STOP (plus PARITY when configured).
  - IDLE: tx = 1. If FIFO non-empty, pop into the shift register and go to START.
  - START: tx = 0 for one bit period, then DATA.
  - DATA: 8 bit periods, tx = shift[0], shifting right. A 3-bit counter tracks bits; after bit 7 go to STOP.
  - STOP: tx = 1 for one bit period, then IDLE.
- Back-to-back frames: the IDLE cycle between frames is one clk cycle, not one bit period.
- Baud counter: 16-bit, counts divisor-1 down to 0; the bit ends at 0. It reloads from BAUDDIV at each bit boundary. A BAUDDIV write mid-bit takes effect at the next boundary.
- busy = (state != IDLE).

## Timing
- Reset (rst = 0, async):
  - tx = 1, state IDLE, FIFO empty.
  - STATUS = 8'h02 (empty only), overflow 0, BAUDDIV = DEFAULT_DIV.
  - data_o follows inputs (0 when not reading).
- Reset asserted mid-frame: tx returns high immediately and FIFO contents are lost.
- Latency (empty FIFO, IDLE):
  - Write at edge k; pop at edge k+1; tx falls after edge k+1.
  - Frame length = 10 × divisor cycles.
  - Next pop occurs at the edge where STOP ends, plus one cycle.
- STATUS reflects the state after the most recent edge. A write followed by a read of STATUS in the next cycle shows the updated count.
- Full/empty are computed from the occupancy count, so count = FIFO_DEPTH is distinguishable from 0.

## Configuration
- UART_TX_PARITY_EN defined:
  - PARITY state is inserted between DATA and STOP; tx = even parity (XOR of the 8 data bits) for one bit period.
  - Frame = 11 bit periods.
  - STATUS bit8 reads 1 (parity capability).
- Undefined: 8N1, 10-bit frames, STATUS bit8 = 0.

## Structure
- Shared package/defines file `uart_defines.v` holds:
  - Register offsets (TXDATA 2'd0, STATUS 2'd1, BAUDDIV 2'd2).
  - STATUS bit positions.
  - State encodings.
  - DEFAULT_DIV.
- Sub-module `sync_fifo` (parameterized width 8, depth FIFO_DEPTH; push/pop/full/empty/count). Simultaneous push and pop when full is legal.
- Top level holds: register decode, baud counter, shift register, FSM.

## Test plan
- Reset: hold rst = 0 mid-frame → tx = 1 immediately; STATUS read = 32'h2; BAUDDIV read = 434.
- Single byte: BAUDDIV = 4, write 8'hA5 → tx pattern 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; the first 0 appears 2 edges after the write.
- Burst: BAUDDIV = 2, write 9 bytes with FIFO_DEPTH = 8 while the first frame is in flight → all 9 frames transmitted back-to-back, overflow = 0. A 10th write issued when count = 8 with no pop → dropped, overflow = 1. Writing STATUS with 32'h8 clears overflow.
- Divisor edge: BAUDDIV = 0 → 1-cycle bits. Rewrite BAUDDIV from 3 to 6 mid-frame → the next bit boundary uses 6.
- Bus rules: read with ce = 0 → data_o = 0. Write with sel = 0 → no push. Read of addr[3:2] = 3 → 0.
- With UART_TX_PARITY_EN: byte 8'h07 → parity bit 1, frame 11 periods; STATUS bit8 = 1.

Source files
------------

// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, FSM state encoding and the default baud divisor.
package uart_tx_mmio_pkg;

   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_BAUDDIV = 2'd2;

   localparam int ST_FULL       = 0;
   localparam int ST_EMPTY      = 1;
   localparam int ST_BUSY       = 2;
   localparam int ST_OVERFLOW   = 3;
   localparam int ST_COUNT_LSB  = 4;
   localparam int ST_PARITY_CAP = 8;

   localparam logic [15:0] DEFAULT_DIV_VAL = 16'd434;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } tx_state_t;

   // A divisor of zero behaves like one, so both reload the counter with 0.
   function automatic logic [15:0] bit_reload(input logic [15:0] div);
      return (div == 16'd0) ? 16'd0 : div - 16'd1;
   endfunction

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Synchronous FIFO (sync_fifo) holding bytes waiting for transmission; the
// occupancy count drives full/empty so a full FIFO is distinct from an empty one.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is still accepted when a pop frees a slot that cycle.
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with byte FIFO, STATUS and BAUDDIV registers.
// Defining UART_TX_PARITY_EN adds an even-parity bit to every frame.
module uart_tx_mmio
   import uart_tx_mmio_pkg::*;
#(
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = DEFAULT_DIV_VAL
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        we,
   input  logic [3:0]  sel,
   input  logic [31:0] addr,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        tx
);

   tx_state_t                     state;
   logic [7:0]                    shift_reg;
   logic [2:0]                    bit_cnt;
   logic [15:0]                   baud_cnt;
   logic [15:0]                   bauddiv;
   logic [15:0]                   reload;
   logic                          bit_end;
   logic                          overflow;
   logic                          wr_en;
   logic [1:0]                    reg_sel;
   logic                          txdata_wr;
   logic                          status_wr;
   logic                          div_wr;
   logic                          fifo_pop;
   logic                          fifo_full;
   logic                          fifo_empty;
   logic [7:0]                    fifo_data;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;
   logic [4:0]                    count_ext;
   logic [31:0]                   status_word;
   logic                          unused_bits;
`ifdef UART_TX_PARITY_EN
   logic                          parity_bit;
`endif

   assign wr_en     = ce & we & (|sel);
   assign reg_sel   = addr[3:2];
   assign txdata_wr = wr_en & (reg_sel == REG_TXDATA);
   assign status_wr = wr_en & (reg_sel == REG_STATUS);
   assign div_wr    = wr_en & (reg_sel == REG_BAUDDIV);
   assign fifo_pop  = (state == S_IDLE) & ~fifo_empty;
   assign reload    = bit_reload(bauddiv);
   assign bit_end   = (baud_cnt == 16'd0);
   assign count_ext = 5'(fifo_count);

   assign unused_bits = ^{addr[31:4], addr[1:0], data_i[31:16], count_ext[4]};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (txdata_wr),
      .push_data (data_i[7:0]),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // A byte is dropped only when the FIFO is full and no frame start frees a slot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow <= 1'b0;
         bauddiv  <= DEFAULT_DIV;
      end else begin
         if (txdata_wr && fifo_full && !fifo_pop)
            overflow <= 1'b1;
         else if (status_wr && data_i[ST_OVERFLOW])
            overflow <= 1'b0;
         if (div_wr)
            bauddiv <= data_i[15:0];
      end
   end

   always_comb begin
      status_word                         = '0;
      status_word[ST_FULL]                = fifo_full;
      status_word[ST_EMPTY]               = fifo_empty;
      status_word[ST_BUSY]                = (state != S_IDLE);
      status_word[ST_OVERFLOW]            = overflow;
      status_word[ST_COUNT_LSB +: 4]      = count_ext[3:0];
`ifdef UART_TX_PARITY_EN
      status_word[ST_PARITY_CAP]          = 1'b1;
`endif
   end

   always_comb begin
      data_o = '0;
      if (ce && !we) begin
         case (reg_sel)
            REG_STATUS:  data_o = status_word;
            REG_BAUDDIV: data_o = {16'h0, bauddiv};
            default:     data_o = '0;
         endcase
      end
   end

   // Each bit lasts until baud_cnt reaches zero; the divisor is re-sampled only
   // at bit boundaries so a mid-bit BAUDDIV write never stretches the current bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         tx         <= 1'b1;
         shift_reg  <= '0;
         bit_cnt    <= '0;
         baud_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               tx <= 1'b1;
               if (!fifo_empty) begin
                  state     <= S_START;
                  tx        <= 1'b0;
                  shift_reg <= fifo_data;
                  baud_cnt  <= reload;
`ifdef UART_TX_PARITY_EN
                  parity_bit <= ^fifo_data;
`endif
               end
            end
            S_START: begin
               if (bit_end) begin
                  state     <= S_DATA;
                  tx        <= shift_reg[0];
                  shift_reg <= shift_reg >> 1;
                  bit_cnt   <= 3'd0;
                  baud_cnt  <= reload;
               end else begin
                  baud_cnt  <= baud_cnt - 16'd1;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  baud_cnt <= reload;
                  if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state <= S_PARITY;
                     tx    <= parity_bit;
`else
                     state <= S_STOP;
                     tx    <= 1'b1;
`endif
                  end else begin
                     tx        <= shift_reg[0];
                     shift_reg <= shift_reg >> 1;
                     bit_cnt   <= bit_cnt + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (bit_end) begin
                  state    <= S_STOP;
                  tx       <= 1'b1;
                  baud_cnt <= reload;
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
`endif
            S_STOP: begin
               if (bit_end) begin
                  state <= S_IDLE;
                  tx    <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            default: begin
               state <= S_IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: expected serial frames and STATUS words
// come from a frame-level reference model (bit arithmetic on queued bytes).
module tb_uart_tx_mmio;

   localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int NBITS = PAR ? 11 : 10;

   logic        clk;
   logic        rst;
   logic        ce;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] addr;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        tx;

   int tests_run;
   int tests_failed;

   logic [7:0] exp_q[$];
   int         started;
   int         accepted;
   bit         exp_ovf;

   uart_tx_mmio #(
      .FIFO_DEPTH  (DEPTH),
      .DEFAULT_DIV (16'd434)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .ce     (ce),
      .we     (we),
      .sel    (sel),
      .addr   (addr),
      .data_i (data_i),
      .data_o (data_o),
      .tx     (tx)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something hangs despite the bounded waits.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Expected STATUS word from the observable queue occupancy and flags.
   function automatic logic [31:0] expStatus(input int cnt, input bit ovf, input bit busy);
      logic [31:0] s;
      s = 32'(cnt) << 4;
      s = s | (32'(ovf) << 3) | (32'(busy) << 2);
      s = s | (32'(cnt == 0) << 1) | 32'(cnt == DEPTH);
      s = s | (32'(PAR) << 8);
      return s;
   endfunction

   // Line level of bit idx of the frame carrying byte b.
   function automatic logic frameBit(input logic [7:0] b, input int idx);
      if (idx == 0)
         return 1'b0;
      if (idx <= 8)
         return b[idx-1];
      if (PAR && idx == 9)
         return ^b;
      return 1'b1;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      ce = 1'b1; we = 1'b1; sel = s; addr = a; data_i = d;
      @(posedge clk);
      #1;
      ce = 1'b0; we = 1'b0; sel = 4'h0;
   endtask

   task automatic readReg(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      ce = 1'b1; we = 1'b0; addr = a;
      #1;
      d = data_o;
      ce = 1'b0;
   endtask

   task automatic waitFrameStart(input string tag);
      int i;
      i = 0;
      while (tx !== 1'b0 && i < 5000) begin
         @(negedge clk);
         i++;
      end
      checkOutput(tag, {31'b0, tx}, 32'h0);
   endtask

   // Called at the negedge showing the first start-bit cycle still to be checked;
   // returns at the negedge of the idle cycle following the stop bit.
   task automatic checkFrame(input logic [7:0] b, input int firstLen, input int div, input string tag);
      for (int idx = 0; idx < NBITS; idx++) begin
         int len;
         len = (idx == 0) ? firstLen : div;
         for (int c = 0; c < len; c++) begin
            checkOutput(tag, {31'b0, tx}, {31'b0, frameBit(b, idx)});
            @(negedge clk);
         end
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic [7:0]  b;
      int          div;

      tests_run = 0; tests_failed = 0;
      started = 0; accepted = 0; exp_ovf = 1'b0;
      ce = 1'b0; we = 1'b0; sel = 4'h0; addr = '0; data_i = '0;
      rst = 1'b1;
      #1 rst = 1'b0;

      // Reset values.
      repeat (2) @(negedge clk);
      checkOutput("reset tx", {31'b0, tx}, 32'h1);
      readReg(32'h4, rd);
      checkOutput("reset status", rd, expStatus(0, 0, 0));
      readReg(32'h8, rd);
      checkOutput("reset bauddiv", rd, 32'd434);
      @(negedge clk);
      rst = 1'b1;

      // Bus rules.
      @(negedge clk);
      addr = 32'h4; we = 1'b0; ce = 1'b0;
      #1 checkOutput("read ce=0", data_o, 32'h0);
      readReg(32'hC, rd);
      checkOutput("read reg3", rd, 32'h0);
      readReg(32'h0, rd);
      checkOutput("read txdata", rd, 32'h0);
      applyStimulus(32'h0, 32'h55, 4'h0);
      readReg(32'h4, rd);
      checkOutput("sel0 no push", rd, expStatus(0, 0, 0));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("sel0 tx idle", {31'b0, tx}, 32'h1);
      end

      // Single byte with divisor 4; start bit appears after the second edge.
      applyStimulus(32'h8, 32'd4, 4'hF);
      readReg(32'h8, rd);
      checkOutput("bauddiv rd", rd, 32'd4);
      applyStimulus(32'h0, 32'hA5, 4'h1);
      readReg(32'h4, rd);
      checkOutput("status after push", rd, expStatus(1, 0, 0));
      checkOutput("latency edge k", {31'b0, tx}, 32'h1);
      @(negedge clk);
      checkFrame(8'hA5, 4, 4, "frame A5");
      readReg(32'h4, rd);
      checkOutput("status idle", rd, expStatus(0, 0, 0));

      // Divisor 0 behaves as 1.
      applyStimulus(32'h8, 32'd0, 4'hF);
      b = 8'($urandom);
      applyStimulus(32'h0, {24'h0, b}, 4'h1);
      @(negedge clk);
      checkOutput("div0 latency", {31'b0, tx}, 32'h1);
      @(negedge clk);
      checkFrame(b, 1, 1, "frame div0");

      // Divisor changed from 3 to 6 during the start bit.
      applyStimulus(32'h8, 32'd3, 4'hF);
      b = 8'($urandom);
      applyStimulus(32'h0, {24'h0, b}, 4'h1);
      @(negedge clk);
      @(negedge clk);
      checkOutput("div change start", {31'b0, tx}, 32'h0);
      ce = 1'b1; we = 1'b1; sel = 4'h3; addr = 32'h8; data_i = 32'd6;
      @(posedge clk);
      #1;
      ce = 1'b0; we = 1'b0; sel = 4'h0;
      @(negedge clk);
      checkFrame(b, 2, 6, "frame div 3->6");

      // Burst of 9 bytes while the first frame is in flight, then one overflowing write.
      applyStimulus(32'h8, 32'd2, 4'hF);
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               logic [7:0] wb;
               wb = 8'($urandom);
               if (i == 9) begin
                  readReg(32'h4, rd);
                  checkOutput("burst status 9", rd, expStatus(8, 0, 1));
               end
               if (accepted - started < DEPTH) begin
                  accepted++;
                  exp_q.push_back(wb);
               end else begin
                  exp_ovf = 1'b1;
               end
               applyStimulus(32'h0, {24'h0, wb}, 4'h1);
            end
            readReg(32'h4, rd);
            checkOutput("overflow set", rd, expStatus(8, exp_ovf, 1));
            applyStimulus(32'h4, 32'h8, 4'h1);
            readReg(32'h4, rd);
            checkOutput("overflow clear", rd, expStatus(8, 0, 1));
         end
         begin
            waitFrameStart("burst first start");
            for (int f = 0; f < 9; f++) begin
               logic [7:0] eb;
               started++;
               eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
               checkFrame(eb, 2, 2, "burst frame");
               checkOutput("burst idle gap", {31'b0, tx}, 32'h1);
               @(negedge clk);
            end
         end
      join
      checkOutput("burst all sent", 32'(exp_q.size()), 32'h0);
      checkOutput("burst no extra", {31'b0, tx}, 32'h1);
      readReg(32'h4, rd);
      checkOutput("burst end status", rd, expStatus(0, 0, 0));

      // Random divisors and bytes, plus 8'h07 for the parity case.
      for (int t = 0; t < 4; t++) begin
         div = (t == 0) ? 3 : int'($urandom_range(1, 5));
         b   = (t == 0) ? 8'h07 : 8'($urandom);
         applyStimulus(32'h8, 32'(div), 4'hF);
         applyStimulus(32'h0, {24'h0, b}, 4'h1);
         @(negedge clk);
         checkOutput("rand latency", {31'b0, tx}, 32'h1);
         @(negedge clk);
         checkFrame(b, div, div, "rand frame");
      end

      // Reset in the middle of a frame with another byte queued.
      applyStimulus(32'h8, 32'd4, 4'hF);
      applyStimulus(32'h0, 32'h3C, 4'h1);
      applyStimulus(32'h0, 32'hC3, 4'h1);
      waitFrameStart("rst frame start");
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1 checkOutput("rst mid tx", {31'b0, tx}, 32'h1);
      readReg(32'h4, rd);
      checkOutput("rst mid status", rd, expStatus(0, 0, 0));
      readReg(32'h8, rd);
      checkOutput("rst mid bauddiv", rd, 32'd434);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         checkOutput("rst fifo lost", {31'b0, tx}, 32'h1);
      end
      readReg(32'h4, rd);
      checkOutput("rst end status", rd, expStatus(0, 0, 0));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
